// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Clocked valid/ready front end for the combinational alu: issue,
//            hold for SETTLE cycles, capture, respond. Optional statistics
//            counters are enabled with `define ALU_SEQUENCER_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module alu_sequencer #(
  parameter int SIZE   = 8,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_command,
  input  logic [SIZE-1:0]     req_a,
  input  logic [SIZE-1:0]     req_b,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [2*SIZE-1:0]   resp_result,
  output logic                resp_overflow,
  output logic                busy,
  output logic                alu_enable,
  output logic [3:0]          alu_command,
  output logic [SIZE-1:0]     alu_a,
  output logic [SIZE-1:0]     alu_b,
  input  logic                alu_overflow,
  input  logic [2*SIZE-1:0]   alu_result
`ifdef ALU_SEQUENCER_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [15:0]         op_count,
  output logic [15:0]         ovf_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_settle_load = 4'(SETTLE - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_settle_cnt;
  logic        w_accept;
  logic        w_capture;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_settle_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operands stay on the ALU after capture; only enable drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_settle_cnt  <= 4'd0;
      alu_enable    <= 1'b0;
      alu_command   <= 4'd0;
      alu_a         <= '0;
      alu_b         <= '0;
      resp_result   <= '0;
      resp_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        alu_command  <= req_command;
        alu_a        <= req_a;
        alu_b        <= req_b;
        alu_enable   <= 1'b1;
        r_settle_cnt <= c_settle_load;
      end else if (w_capture) begin
        resp_result   <= alu_result;
        resp_overflow <= alu_overflow;
        alu_enable    <= 1'b0;
      end else if (r_state == ST_EXEC) begin
        r_settle_cnt <= r_settle_cnt - 4'd1;
      end
    end
  end

`ifdef ALU_SEQUENCER_STATS_EN
  // Saturating counters; a clear wins over a coincident capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count  <= 16'd0;
      ovf_count <= 16'd0;
    end else if (stats_clr) begin
      op_count  <= 16'd0;
      ovf_count <= 16'd0;
    end else if (w_capture) begin
      if (op_count != 16'hFFFF) begin
        op_count <= op_count + 16'd1;
      end
      if (alu_overflow && (ovf_count != 16'hFFFF)) begin
        ovf_count <= ovf_count + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
